// File: rtl/eeprom_rw_sequencer_pkg.sv
// Shared types and constants for the EEPROM read/write sequencer.
// Also holds the per-state byte-command encoding.
package eeprom_pkg;

  typedef enum logic [3:0] {
    IDLE, CTRL_W, MEM_A, WR_DATA, GAP, POLL, RS_CTRL_R, RD_DATA, ABORT, RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_CTRL_NACK = 2'd1,
    ERR_DATA_NACK = 2'd2,
    ERR_POLL_TO   = 2'd3
  } err_t;

  localparam logic       RW_WRITE       = 1'b0;
  localparam logic       RW_READ        = 1'b1;
  localparam logic [7:0] STOP_ONLY_BYTE = 8'hFF;

  typedef struct packed {
    logic       we;
    logic [6:0] dev;
    logic [7:0] mem;
    logic [7:0] wdata;
  } req_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       nack;
    logic [7:0] tx;
  } cmd_t;

  function automatic logic is_cmd_state(input state_t s);
    return s inside {CTRL_W, MEM_A, WR_DATA, POLL, RS_CTRL_R, RD_DATA, ABORT};
  endfunction

  function automatic cmd_t cmd_for(input state_t s, input req_t r);
    cmd_t c;
    c = '0;
    case (s)
      CTRL_W:    begin c.start = 1'b1; c.tx = {r.dev, RW_WRITE}; end
      MEM_A:     c.tx = r.mem;
      WR_DATA:   begin c.stop = 1'b1; c.tx = r.wdata; end
      POLL:      begin c.start = 1'b1; c.stop = 1'b1; c.tx = {r.dev, RW_WRITE}; end
      RS_CTRL_R: begin c.start = 1'b1; c.tx = {r.dev, RW_READ}; end
      RD_DATA:   begin c.read = 1'b1; c.nack = 1'b1; c.stop = 1'b1; c.tx = STOP_ONLY_BYTE; end
      ABORT:     begin c.stop = 1'b1; c.tx = STOP_ONLY_BYTE; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/eeprom_rw_sequencer_if.sv
// Request/response and byte-command signals of the EEPROM sequencer.
// slave = sequencer side, master = user logic plus byte master side.
interface eeprom_rw_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [6:0] req_dev_addr;
  logic [7:0] req_mem_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       cmd_valid;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] cmd_txdata;
  logic       cmd_done;
  logic [7:0] cmd_rxdata;
  logic       cmd_rx_nack;

  modport slave (
    input  req_valid, req_we, req_dev_addr, req_mem_addr, req_wdata,
           cmd_done, cmd_rxdata, cmd_rx_nack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_txdata
  );

  modport master (
    output req_valid, req_we, req_dev_addr, req_mem_addr, req_wdata,
           cmd_done, cmd_rxdata, cmd_rx_nack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_nack, cmd_txdata
  );
endinterface

// File: rtl/eeprom_rw_sequencer_poll_timer.sv
// Idle-gap down-counter between ACK polls: expire is high in the
// GAP-th cycle after start.
module eeprom_poll_timer #(
  parameter int unsigned GAP = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expire
);
  localparam int unsigned W = (GAP < 2) ? 1 : $clog2(GAP + 1);

  logic [W-1:0] cnt;
  logic         busy;

  assign expire = busy && (cnt == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= W'(GAP);
      busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - W'(1);
      if (cnt == W'(1)) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/eeprom_rw_sequencer.sv
// Turns single-byte EEPROM read/write requests into byte-master commands,
// with ACK polling after writes and an error code per response.
module eeprom_rw_sequencer #(
  parameter int unsigned POLL_MAX = 255,
  parameter int unsigned POLL_GAP = 500
) (
  input logic clk,
  input logic rst_n,
  eeprom_rw_sequencer_if.slave bus
);
  import eeprom_pkg::*;

  state_t     state_q, state_d;
  req_t       req_q, req_d;
  cmd_t       cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  err_t       err_q, err_d, rsp_err_q, rsp_err_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0] poll_q, poll_d;
  logic       timer_start, timer_expire, done;

  eeprom_poll_timer #(.GAP(POLL_GAP)) u_gap (
    .clk(clk), .rst_n(rst_n), .start(timer_start), .expire(timer_expire)
  );

  assign done = cmd_valid_q && bus.cmd_done;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_d       = err_q;
    poll_d      = poll_q;
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_start = 1'b0;

    // A command state launches only from cmd_valid=0, so every command is
    // preceded by at least one idle cycle after the previous cmd_done.
    if (done) begin
      cmd_valid_d = 1'b0;
      cmd_d       = '0;
    end else if (!cmd_valid_q && is_cmd_state(state_q)) begin
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_for(state_q, req_q);
    end

    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d   = '{we: bus.req_we, dev: bus.req_dev_addr,
                    mem: bus.req_mem_addr, wdata: bus.req_wdata};
        state_d = CTRL_W;
      end
      CTRL_W: if (done) begin
        if (bus.cmd_rx_nack) begin err_d = ERR_CTRL_NACK; state_d = ABORT; end
        else state_d = MEM_A;
      end
      MEM_A: if (done) begin
        if (bus.cmd_rx_nack) begin err_d = ERR_DATA_NACK; state_d = ABORT; end
        else state_d = req_q.we ? WR_DATA : RS_CTRL_R;
      end
      WR_DATA: if (done) begin
        if (bus.cmd_rx_nack) begin
          state_d = RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_DATA_NACK; rsp_rdata_d = '0;
        end else begin
          poll_d = '0; timer_start = 1'b1; state_d = GAP;
        end
      end
      GAP: if (timer_expire) state_d = POLL;
      POLL: if (done) begin
        poll_d = poll_q + 8'd1;
        if (!bus.cmd_rx_nack) begin
          state_d = RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_OK; rsp_rdata_d = '0;
        end else if (poll_d == 8'(POLL_MAX)) begin
          state_d = RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_POLL_TO; rsp_rdata_d = '0;
        end else begin
          timer_start = 1'b1; state_d = GAP;
        end
      end
      RS_CTRL_R: if (done) begin
        if (bus.cmd_rx_nack) begin err_d = ERR_CTRL_NACK; state_d = ABORT; end
        else state_d = RD_DATA;
      end
      RD_DATA: if (done) begin
        state_d = RESP; rsp_valid_d = 1'b1; rsp_err_d = ERR_OK; rsp_rdata_d = bus.cmd_rxdata;
      end
      ABORT: if (done) begin
        state_d = RESP; rsp_valid_d = 1'b1; rsp_err_d = err_q;
        if (req_q.we) rsp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      err_q       <= ERR_OK;
      poll_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      err_q       <= err_d;
      poll_q      <= poll_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_start  = cmd_q.start;
  assign bus.cmd_stop   = cmd_q.stop;
  assign bus.cmd_read   = cmd_q.read;
  assign bus.cmd_nack   = cmd_q.nack;
  assign bus.cmd_txdata = cmd_q.tx;
endmodule
